// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame definitions used by both the transmit and
// receive stages, so frame format and parity sense stay in lock-step.
//   - default line parameters (clock, baud, data width, parity sense)
//   - FSM state encodings (3-bit)
//   - bit-period divider and parity helpers
package uart_pkg;

  localparam int unsigned CLK_FREQ_DEF     = 40000000;
  localparam int unsigned BAUD_DEF         = 38400;
  localparam int unsigned DATA_BIT_NUM_DEF = 8;
  localparam bit          PARITY_ODD_DEF   = 1'b1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Clock cycles per bit period, truncated toward zero.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

  localparam int unsigned DIV_DEF = calc_div(CLK_FREQ_DEF, BAUD_DEF);

  // Parity bit for a data word; zero-extension of narrower words does not
  // change the XOR reduction. odd=1 makes data+parity carry an odd number of 1s.
  function automatic logic calc_parity(input logic [31:0] data,
                                       input logic        odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period timer.
//   clk     - system clock
//   rst_n   - asynchronous active-low reset
//   restart - holds the counter at 0 while high
//   bit_end - one-cycle pulse in the last cycle (count DIV-1) of a bit period
module uart_baud_tick #(
  parameter int unsigned DIV = 1041
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_end
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          last_s;

  assign last_s  = (cnt_q == CW'(DIV - 1));
  assign bit_end = last_s && !restart;

  // Next count: hold at 0 on restart, wrap after the last cycle of a period.
  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = {CW{1'b0}};
    end else if (last_s) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter, frame = start, DATA_BIT_NUM data bits
// LSB-first, parity, stop. A one-entry holding register behind a valid/ready
// handshake lets the producer queue the next byte while a frame shifts out.
//   clk       - system clock
//   rst_n     - asynchronous active-low reset (abandons any frame and byte)
//   din       - byte to send
//   din_valid - producer has a byte on din
//   din_ready - holding register can accept a byte (registered)
//   txd       - serial line, idles high (registered)
//   busy      - a frame is on the line (registered)
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = CLK_FREQ_DEF,
  parameter int unsigned BAUD         = BAUD_DEF,
  parameter int unsigned DATA_BIT_NUM = DATA_BIT_NUM_DEF,
  parameter bit          PARITY_ODD   = PARITY_ODD_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_BIT_NUM-1:0] din,
  input  logic                    din_valid,
  output logic                    din_ready,
  output logic                    txd,
  output logic                    busy
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD);
  localparam int unsigned BW  = (DATA_BIT_NUM > 1) ? $clog2(DATA_BIT_NUM) : 1;

  logic [2:0]              state_q, state_d;
  logic [DATA_BIT_NUM-1:0] hold_q, hold_d;
  logic                    hold_full_q, hold_full_d;
  logic [DATA_BIT_NUM-1:0] shift_q, shift_d;
  logic                    parity_q, parity_d;
  logic [BW-1:0]           bitcnt_q, bitcnt_d;
  logic                    txd_q, txd_d;
  logic                    busy_q, busy_d;
  logic                    ready_q, ready_d;

  logic                    load_s;
  logic                    accept_s;
  logic                    bit_end_s;
  logic                    restart_s;
  logic                    last_bit_s;

  assign din_ready = ready_q;
  assign txd       = txd_q;
  assign busy      = busy_q;

  assign accept_s   = din_valid && ready_q;
  // Counter sits at 0 in IDLE, so leaving IDLE always starts a fresh period.
  assign restart_s  = (state_q == ST_IDLE);
  assign last_bit_s = (bitcnt_q == BW'(DATA_BIT_NUM - 1));

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart_s),
    .bit_end (bit_end_s)
  );

  // Next-state logic; load_s marks moving the held byte into the shifter.
  always_comb begin
    state_d = state_q;
    load_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          state_d = ST_START;
          load_s  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s && last_bit_s) begin
          state_d = ST_PARITY;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (bit_end_s && hold_full_q) begin
          // Chain straight into the next start bit: no idle gap.
          state_d = ST_START;
          load_s  = 1'b1;
        end else if (bit_end_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath next values: holding register, shifter, parity, bit counter.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    bitcnt_d    = bitcnt_q;

    // load_s needs hold_full_q=1, which keeps ready low, so these never collide.
    if (load_s) begin
      hold_full_d = 1'b0;
    end else if (accept_s) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end else begin
      hold_full_d = hold_full_q;
    end

    if (load_s) begin
      shift_d  = hold_q;
      parity_d = calc_parity(32'(hold_q), PARITY_ODD);
      bitcnt_d = {BW{1'b0}};
    end else if ((state_q == ST_DATA) && bit_end_s) begin
      shift_d  = shift_q >> 1;
      bitcnt_d = last_bit_s ? {BW{1'b0}} : (bitcnt_q + BW'(1));
    end else begin
      shift_d  = shift_q;
    end
  end

  // Output logic, computed from the next state so outputs leave flops.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      ST_IDLE:   txd_d = 1'b1;
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_d[0];
      ST_PARITY: txd_d = parity_d;
      ST_STOP:   txd_d = 1'b1;
      default:   txd_d = 1'b1;
    endcase
    busy_d  = (state_d != ST_IDLE);
    // Ready returns one cycle after the held byte is loaded.
    ready_d = !hold_full_d && !load_s;
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hold_q      <= {DATA_BIT_NUM{1'b0}};
      hold_full_q <= 1'b0;
      shift_q     <= {DATA_BIT_NUM{1'b0}};
      parity_q    <= 1'b0;
      bitcnt_q    <= {BW{1'b0}};
      txd_q       <= 1'b1;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      bitcnt_q    <= bitcnt_d;
      txd_q       <= txd_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed bench. One full-rate instance (DIV=1041, odd
// parity) covers bit timing, back-to-back and mid-frame reset; two fast
// instances (DIV=16, odd and even parity) share stimulus for parity sense and
// backpressure.
module tb_uart_tx_frame;

  localparam int M_DIV = 1041;
  localparam int S_DIV = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready, txd, busy;
  logic [7:0] s_din;
  logic       s_valid;
  logic       s_ready, s_txd, s_busy;
  logic       e_ready, e_txd, e_busy;

  int n_checks = 0;
  int n_errors = 0;
  int bp_hits;

  logic [63:0] fs, ls, so_bits, se_bits;
  int          bcyc, rlow, quiet;

  always #5 clk = ~clk;

  uart_tx_frame u_dut (
    .clk (clk), .rst_n (rst_n), .din (din), .din_valid (din_valid),
    .din_ready (din_ready), .txd (txd), .busy (busy)
  );

  uart_tx_frame #(
    .CLK_FREQ (40000000), .BAUD (2500000), .DATA_BIT_NUM (8), .PARITY_ODD (1'b1)
  ) u_odd (
    .clk (clk), .rst_n (rst_n), .din (s_din), .din_valid (s_valid),
    .din_ready (s_ready), .txd (s_txd), .busy (s_busy)
  );

  uart_tx_frame #(
    .CLK_FREQ (40000000), .BAUD (2500000), .DATA_BIT_NUM (8), .PARITY_ODD (1'b0)
  ) u_even (
    .clk (clk), .rst_n (rst_n), .din (s_din), .din_valid (s_valid),
    .din_ready (e_ready), .txd (e_txd), .busy (e_busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Offer a byte to the full-rate DUT; returns on the negedge after the accept.
  task automatic push_main(input logic [7:0] b);
    int w;
    din = b; din_valid = 1'b1; w = 0;
    while (din_ready !== 1'b1 && w < 30000) begin @(negedge clk); w++; end
    if (w >= 30000) check_eq("push_main_timeout", 64'(w), 64'd0);
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic push_small(input logic [7:0] b);
    int w;
    s_din = b; s_valid = 1'b1; w = 0;
    while (s_ready !== 1'b1 && w < 30000) begin @(negedge clk); w++; end
    if (w >= 30000) check_eq("push_small_timeout", 64'(w), 64'd0);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Record txd at the first and last cycle of every bit period while busy.
  task automatic capture_main(output logic [63:0] f, output logic [63:0] l,
                              output int bc, output int rl);
    int w, c;
    f = '0; l = '0; rl = 0; w = 0; c = 0;
    while (txd !== 1'b0 && w < 100) begin @(negedge clk); w++; end
    if (w >= 100) check_eq("main_start_timeout", 64'(w), 64'd0);
    while (busy === 1'b1 && c < 30000) begin
      if (c / M_DIV < 64) begin
        if (c % M_DIV == 0)         f[c / M_DIV] = txd;
        if (c % M_DIV == M_DIV - 1) l[c / M_DIV] = txd;
      end
      if (din_ready === 1'b0) rl++;
      c++;
      @(negedge clk);
    end
    bc = c;
  endtask

  // Mid-bit samples of both fast DUTs.
  task automatic capture_small(output logic [63:0] so, output logic [63:0] se,
                               output int bc, output int rl);
    int w, c;
    so = '0; se = '0; rl = 0; w = 0; c = 0;
    while (s_txd !== 1'b0 && w < 100) begin @(negedge clk); w++; end
    if (w >= 100) check_eq("small_start_timeout", 64'(w), 64'd0);
    while (s_busy === 1'b1 && c < 30000) begin
      if ((c % S_DIV == S_DIV / 2) && (c / S_DIV < 64)) begin
        so[c / S_DIV] = s_txd;
        se[c / S_DIV] = e_txd;
      end
      if (s_ready === 1'b0) rl++;
      c++;
      @(negedge clk);
    end
    bc = c;
  endtask

  initial begin
    rst_n = 1'b0; din = 8'h00; din_valid = 1'b0; s_din = 8'h00; s_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_txd", 64'(txd), 64'd1);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_ready", 64'(din_ready), 64'd1);
    check_eq("rst_small_txd", 64'({s_txd, e_txd}), 64'd3);
    check_eq("rst_small_ready", 64'({s_ready, e_ready}), 64'd3);
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte 0x55: odd parity 1.
    push_main(8'h55);
    check_eq("acc_ready_low", 64'(din_ready), 64'd0);
    check_eq("acc_txd_still_idle", 64'({txd, busy}), 64'b10);
    @(negedge clk);
    check_eq("load_txd_busy", 64'({txd, busy}), 64'b01);
    capture_main(fs, ls, bcyc, rlow);
    check_eq("b55_bit_first", fs, 64'({1'b1, 1'b1, 8'h55, 1'b0}));
    check_eq("b55_bit_last", ls, 64'({1'b1, 1'b1, 8'h55, 1'b0}));
    check_eq("b55_busy_len", 64'(bcyc), 64'd11451);
    check_eq("b55_ready_low", 64'(rlow), 64'd1);
    check_eq("b55_idle_after", 64'({txd, busy, din_ready}), 64'b101);

    // Back-to-back 0xA5 then 0x3C, both with odd parity 1.
    repeat (5) @(negedge clk);
    push_main(8'hA5);
    fork
      push_main(8'h3C);
      capture_main(fs, ls, bcyc, rlow);
    join
    check_eq("b2b_bits", fs,
             64'({1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}));
    check_eq("b2b_bits_last", ls,
             64'({1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}));
    check_eq("b2b_busy_len", 64'(bcyc), 64'd22902);
    check_eq("b2b_ready_low", 64'(rlow), 64'd11451);

    // Parity sense and backpressure on the fast pair: 0x00, 0x01, 0xFF,
    // with 0xEE offered while the holding register is full.
    push_small(8'h00);
    fork
      begin
        push_small(8'h01);
        s_din = 8'hEE; s_valid = 1'b1; bp_hits = 0;
        for (int i = 0; i < 8; i++) begin
          if (s_ready !== 1'b0 || e_ready !== 1'b0) bp_hits++;
          @(negedge clk);
        end
        check_eq("bp_ready_low", 64'(bp_hits), 64'd0);
        push_small(8'hFF);
      end
      capture_small(so_bits, se_bits, bcyc, rlow);
    join
    check_eq("par_odd_bits", so_bits,
             64'({1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h01, 1'b0,
                  1'b1, 1'b1, 8'h00, 1'b0}));
    check_eq("par_even_bits", se_bits,
             64'({1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0,
                  1'b1, 1'b0, 8'h00, 1'b0}));
    check_eq("small_busy_len", 64'(bcyc), 64'd528);
    check_eq("small_ready_low", 64'(rlow), 64'd351);

    // Reset during data bit 3 of 0x96 with 0x5A pending.
    repeat (5) @(negedge clk);
    push_main(8'h96);
    push_main(8'h5A);
    repeat (4682) @(negedge clk);
    check_eq("pre_rst_bit3", 64'({txd, busy, din_ready}), 64'b010);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_async", 64'({txd, busy, din_ready}), 64'b101);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    quiet = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || txd !== 1'b1) quiet++;
    end
    check_eq("post_rst_silent", 64'(quiet), 64'd0);
    check_eq("post_rst_ready", 64'(din_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
